// File: rtl/adc_decimator.sv
// Per-channel decimation by 2^D (subsample / boxcar average) with repacking into 64-bit words.
// Optional ADC_DECIM_PEAK_EN adds signed max (mode 10) / min (mode 11) group results.
module adc_decimator #(
  parameter int LANES = 8,
  parameter int SW    = 8
) (
  input  logic                  divclk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  in_valid,
  input  logic [LANES*SW-1:0]   in_data,
  input  logic [1:0]            cfg_ch,
  input  logic [2:0]            cfg_decim_log2,
  input  logic [1:0]            cfg_mode,
  output logic                  out_valid,
  output logic [LANES*SW-1:0]   out_data,
  output logic [1:0]            cfg_ch_act,
  output logic [2:0]            cfg_decim_act
);
  localparam int AW = 15;

  logic [1:0]               ch_q, ch_d, mode_q, mode_d;
  logic [2:0]               dec_q, dec_d;
  logic                     pend_q, pend_d;
  logic [6:0]               cnt_q, cnt_d;
  logic [LANES-1:0][AW-1:0] acc_q, acc_d;
  logic                     out_valid_q, out_valid_d;
  logic [LANES*SW-1:0]      out_data_q, out_data_d;

  logic [AW-1:0]            acc_n [LANES];
  logic [SW-1:0]            res   [LANES];

  // Right after reset the shadow registers still hold reset values, so the
  // first cycle uses the live config and latches it.
  logic [1:0] ch_e, mode_e;
  logic [2:0] dec_e;
  logic [1:0] nl;
  logic [2:0] nmask;
  logic [9:0] rmask;
  logic       last;

  assign ch_e   = pend_q ? cfg_ch         : ch_q;
  assign dec_e  = pend_q ? cfg_decim_log2 : dec_q;
  assign mode_e = pend_q ? cfg_mode       : mode_q;
  assign nl     = (ch_e == 2'b00) ? 2'd0 : (ch_e == 2'b01) ? 2'd1 : 2'd2;
  assign nmask  = (3'd1 << nl) - 3'd1;
  assign rmask  = (10'd1 << dec_e) - 10'd1;
  assign last   = (cnt_q == rmask[6:0]);

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [AW-1:0]        an, rnd, sum;
    logic signed [AW-1:0] sh;
    logic [9:0]           idx;
    logic [SW-1:0]        s;

    // Output lane j holds group (j>>nl) of channel (j&nmask). Input lanes are
    // scanned in time order, so a group's first sample is always its first
    // member seen and re-seeds the accumulator.
    always_comb begin
      an  = acc_q[j];
      idx = '0;
      s   = '0;
      for (int k = 0; k < LANES; k++) begin
        idx = ({3'b000, cnt_q} << (2'd3 - nl)) + 10'(k >> nl);
        s   = in_data[k*SW +: SW];
        if (((3'(k) & nmask) == (3'(j) & nmask)) && ((idx >> dec_e) == 10'(j >> nl))) begin
          if ((idx & rmask) == 10'd0) begin
            an = {{(AW-SW){s[SW-1]}}, s};
          end else begin
            case (mode_e)
              2'b01: an = an + {{(AW-SW){s[SW-1]}}, s};
`ifdef ADC_DECIM_PEAK_EN
              2'b10: if ($signed(s) > $signed(an[SW-1:0])) an = {{(AW-SW){s[SW-1]}}, s};
              2'b11: if ($signed(s) < $signed(an[SW-1:0])) an = {{(AW-SW){s[SW-1]}}, s};
`endif
              default: an = an;
            endcase
          end
        end
      end
      rnd = (dec_e == 3'd0) ? '0 : (AW'(1) << (dec_e - 3'd1));
      sum = an + rnd;
      sh  = $signed(sum) >>> dec_e;
    end

    assign acc_n[j] = an;
    assign res[j]   = (mode_e == 2'b01) ? sh[SW-1:0] : an[SW-1:0];
  end

  always_comb begin
    ch_d        = ch_e;
    dec_d       = dec_e;
    mode_d      = mode_e;
    pend_d      = 1'b0;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    if (clr) begin
      cnt_d  = '0;
      acc_d  = '0;
      ch_d   = cfg_ch;
      dec_d  = cfg_decim_log2;
      mode_d = cfg_mode;
    end else if (in_valid) begin
      for (int j = 0; j < LANES; j++) acc_d[j] = acc_n[j];
      if (last) begin
        cnt_d       = '0;
        out_valid_d = 1'b1;
        for (int j = 0; j < LANES; j++) out_data_d[j*SW +: SW] = res[j];
        ch_d        = cfg_ch;
        dec_d       = cfg_decim_log2;
        mode_d      = cfg_mode;
      end else begin
        cnt_d = cnt_q + 7'd1;
      end
    end
  end

  always_ff @(posedge divclk or posedge rst) begin
    if (rst) begin
      ch_q        <= '0;
      dec_q       <= '0;
      mode_q      <= '0;
      pend_q      <= 1'b1;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      ch_q        <= ch_d;
      dec_q       <= dec_d;
      mode_q      <= mode_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign cfg_ch_act    = ch_q;
  assign cfg_decim_act = dec_q;
endmodule

// File: tb/tb_adc_decimator.sv
// Scoreboard bench for adc_decimator: a sample-list reference model predicts each
// output word and its due cycle; the monitor pops and compares on out_valid.
module tb_adc_decimator;
  logic        divclk = 1'b0;
  logic        rst, clr, in_valid;
  logic [63:0] in_data;
  logic [1:0]  cfg_ch, cfg_mode;
  logic [2:0]  cfg_decim_log2;
  logic        out_valid;
  logic [63:0] out_data;
  logic [1:0]  cfg_ch_act;
  logic [2:0]  cfg_decim_act;

  adc_decimator dut (
    .divclk(divclk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .cfg_ch(cfg_ch), .cfg_decim_log2(cfg_decim_log2), .cfg_mode(cfg_mode),
    .out_valid(out_valid), .out_data(out_data),
    .cfg_ch_act(cfg_ch_act), .cfg_decim_act(cfg_decim_act)
  );

  always #5 divclk = ~divclk;

  typedef struct { logic [63:0] data; int due; } exp_t;
  exp_t        sbq[$];
  exp_t        mon_e;
  logic [63:0] fb[$];
  logic [1:0]  m_ch, m_mode;
  logic [2:0]  m_d;
  int          n_chk = 0, n_err = 0, cyc = 0, nout = 0, nout0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge divclk) cyc <= cyc + 1;

  always @(negedge divclk) begin
    if (!rst && out_valid) begin
      nout++;
      if (sbq.size() == 0) chk("spurious_out", 64'd1, 64'd0);
      else begin
        mon_e = sbq.pop_front();
        chk("data", out_data, mon_e.data);
        chk("latency", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  // Reference: build each channel's sample list, then reduce groups of R.
  function automatic logic [63:0] model();
    int N, S, R, n, lane, v, sum, mx, mn, first, r_val;
    logic [63:0]      w, o;
    logic signed [7:0] b;
    o = '0;
    N = (m_ch == 2'b00) ? 1 : (m_ch == 2'b01) ? 2 : 4;
    S = 8 / N;
    R = 1 << m_d;
    for (int c = 0; c < N; c++)
      for (int g = 0; g < S; g++) begin
        sum = 0; mx = -1000; mn = 1000; first = 0;
        for (int r = 0; r < R; r++) begin
          n = g * R + r;
          w = fb[n / S];
          lane = c + (n % S) * N;
          b = w[8*lane +: 8];
          v = b;
          if (r == 0) first = v;
          sum += v;
          if (v > mx) mx = v;
          if (v < mn) mn = v;
        end
        case (m_mode)
          2'b01: r_val = (sum + R / 2) >>> m_d;
`ifdef ADC_DECIM_PEAK_EN
          2'b10: r_val = mx;
          2'b11: r_val = mn;
`endif
          default: r_val = first;
        endcase
        o[8*(c + g*N) +: 8] = r_val[7:0];
      end
    return o;
  endfunction

  task automatic relatch();
    m_ch = cfg_ch; m_d = cfg_decim_log2; m_mode = cfg_mode;
  endtask

  task automatic send(input logic [63:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge divclk); #1;
    fb.push_back(d);
    if (fb.size() == (1 << m_d)) begin
      sbq.push_back('{model(), cyc});
      fb.delete();
      relatch();
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge divclk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1; in_valid = 1'b1; in_data = {$urandom, $urandom};
    @(posedge divclk); #1;
    clr = 1'b0; in_valid = 1'b0;
    fb.delete();
    relatch();
  endtask

  task automatic cfg_set(input logic [1:0] ch, input logic [2:0] d, input logic [1:0] mode);
    cfg_ch = ch; cfg_decim_log2 = d; cfg_mode = mode;
    do_clr();
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    cfg_ch = 2'b01; cfg_decim_log2 = 3'd3; cfg_mode = 2'b01;
    repeat (3) @(posedge divclk); #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_cfg_ch_act", 64'(cfg_ch_act), 64'd0);
    chk("rst_cfg_decim_act", 64'(cfg_decim_act), 64'd0);
    rst = 1'b0;
    @(posedge divclk); #1;
    chk("post_rst_ch_act", 64'(cfg_ch_act), 64'd1);
    chk("post_rst_decim_act", 64'(cfg_decim_act), 64'd3);
    relatch();

    // D=0 passthrough in each mode
    cfg_set(2'b00, 3'd0, 2'b00); send(64'h7766554433221100);
    cfg_set(2'b00, 3'd0, 2'b01); send(64'h7766554433221100);
    cfg_set(2'b10, 3'd0, 2'b10); send(64'h7766554433221100);
    idle(2);

    // 1ch, D=1 subsample
    cfg_set(2'b00, 3'd1, 2'b00);
    send(64'h0706050403020100); send(64'h0F0E0D0C0B0A0908);
    idle(2);

    // 2ch, D=3 average, constant and round-half-up patterns
    cfg_set(2'b01, 3'd3, 2'b01);
    repeat (8) send(64'hF010F010F010F010);
    repeat (8) send(64'hF004F003F004F003);
    idle(2);

    // continuous stream, D=2: exactly 25 outputs per 100 words
    cfg_set(2'b10, 3'd2, 2'b00);
    nout0 = nout;
    for (int w = 0; w < 100; w++) send({$urandom, $urandom});
    idle(2);
    chk("count_25", 64'(nout - nout0), 64'd25);

    // mid-frame ratio change only takes effect at the next frame boundary
    cfg_set(2'b00, 3'd2, 2'b01);
    nout0 = nout;
    for (int w = 0; w < 60; w++) begin
      if (w == 50) cfg_decim_log2 = 3'd1;
      send({$urandom, $urandom});
    end
    idle(2);
    chk("count_change", 64'(nout - nout0), 64'd17);

    // clr drops a partial frame
    cfg_set(2'b01, 3'd2, 2'b01);
    nout0 = nout;
    repeat (3) send({$urandom, $urandom});
    idle(1);
    chk("clr_no_out", 64'(nout - nout0), 64'd0);
    do_clr();
    repeat (4) send({$urandom, $urandom});
    idle(2);
    chk("clr_count", 64'(nout - nout0), 64'd1);

    // gaps mid-frame, average, 4ch and cfg_ch=11
    cfg_set(2'b10, 3'd2, 2'b01);
    repeat (8) begin send({$urandom, $urandom}); idle($urandom_range(0, 3)); end
    cfg_set(2'b11, 3'd1, 2'b01);
    repeat (6) begin send({$urandom, $urandom}); idle($urandom_range(0, 2)); end
    idle(2);

    // peak modes (subsample when peak feature absent), D=7, 1ch
    for (int m = 2; m < 4; m++) begin
      cfg_set(2'b00, 3'd7, 2'(m));
      for (int w = 0; w < 128; w++)
        send((w == 5) ? 64'h80807F8080808080 : 64'h8080808080808080);
      idle(2);
    end

    idle(3);
    chk("drain", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/adc_decimator.md
Name: adc_decimator

Overview:
- Sample-rate reduction stage in the divclk domain.
- Sits between the channel-ordering/two's-complement stage and adc_to_datamover.
- Consumes one 64-bit word (8 signed 8-bit samples) per valid cycle and decimates each channel by 2^D, using subsample or boxcar-average mode.
- Repacks the decimated samples into full 64-bit words in the same channel layout, emitting exactly one output word per 2^D accepted input words.

Parameters:
- LANES, 8, samples per word (fixed at 8; other values unsupported)
- SW, 8, sample width in bits

Ports:
- divclk  input  1  sample clock; all logic on its rising edge
- rst  input  1  asynchronous active-high reset
- clr  input  1  synchronous restart: flush accumulators/packer, relatch config
- in_valid  input  1  in_data valid this cycle; no backpressure
- in_data  input  64  lane k = bits [8k+7:8k], signed; lane 0 earliest
- cfg_ch  input  2  00=1ch, 01=2ch, 10=4ch, 11=4ch
- cfg_decim_log2  input  3  D; ratio R=2^D (1..128)
- cfg_mode  input  2  00=subsample, 01=average, 1x=see Optional Feature
- out_valid  output  1  single-cycle strobe
- out_data  output  64  decimated word, same lane layout as input
- cfg_ch_act  output  2  currently latched channel setting
- cfg_decim_act  output  3  currently latched D

Behaviour:
- Clock and reset: one clock, divclk. Reset is asynchronous and active-high (rst).
- Reset values: out_valid=0, out_data=0, cfg_ch_act=00, cfg_decim_act=0, accumulators/counters=0, latched mode=subsample.
- Lane layout:
  - N = 1/2/4 channels; lane k belongs to channel k mod N.
  - Time index within word is k div N; S = 8/N samples per channel per word.
- Config latching:
  - cfg_* are sampled into shadow registers only at a frame boundary: after reset, after clr, and in the cycle an output word completes.
  - Changes at other times are ignored until the next boundary.
- Group: R consecutive samples of one channel. Groups may span words (R>S) or be contained in a word (R<=S).
- Subsample: result = first (earliest) sample of each group.
- Average:
  - Signed sum in a 15-bit accumulator.
  - result = (sum + 2^(D-1)) >>> D for D>0; raw sample for D=0.
  - Result always fits 8 bits, so no saturation.
- Packer:
  - Decimated samples of channel c fill lanes c, c+N, c+2N, ... in time order.
  - Word completes after S results per channel, i.e. after exactly R accepted input words.
- Frame counter:
  - Counts accepted words 0..R-1.
  - On the R-th accepted word, out_data/out_valid are registered in the next cycle (latency 1 cycle from the last contributing input).
  - D=0: passthrough with 1-cycle latency in every mode.
- in_valid=0: state holds and out_valid=0. Gaps of any length are permitted mid-frame.
- clr:
  - Priority over in_valid in the same cycle; that input word is discarded.
  - Partial frame is dropped without emitting; out_valid=0 next cycle.
  - Config relatched.
- rst asserted mid-frame: all state cleared immediately; no output emitted.
- cfg_ch=11 behaves exactly as 10.
- No overflow condition exists: output rate <= input rate by construction.

Optional Feature:
- Macro: ADC_DECIM_PEAK_EN.
- Defined:
  - cfg_mode=10 → group result = signed max.
  - cfg_mode=11 → group result = signed min.
  - Comparators are per lane, in parallel with the accumulators.
- Undefined: cfg_mode=1x behaves identically to 00 (subsample) and no comparator logic is built.

Test Plan:
- D=0, any mode, in_data=64'h7766554433221100 valid one cycle → out_valid one cycle later, out_data=64'h7766554433221100.
- cfg_ch=00, D=1, subsample, in_data=64'h0706050403020100 then 64'h0F0E0D0C0B0A0908 → single out_valid after the 2nd word, out_data=64'h0E0C0A0806040200.
- cfg_ch=01, D=3, average, 8 words with all lanes of ch0=8'h10 and ch1=8'hF0 (-16) → one output, ch0 lanes=8'h10, ch1 lanes=8'hF0; ch0 lanes alternating 3 and 4 → result 4 (round half up).
- Continuous valid, D=2 → out_valid every 4th cycle, exact count 25 over 100 words; cfg_decim_log2 changed at word 50 → new ratio active only from the frame starting at word 52.
- clr asserted after 3 of 4 words (D=2) → no out_valid; next 4 words produce one output built only from post-clr data.
- With ADC_DECIM_PEAK_EN, mode=10, D=7, 1ch, one lane spike 8'h7F, rest 8'h80 → that output sample 8'h7F; mode=11 → 8'h80. Without the macro, mode=10 equals subsample output.
